// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
//   sa_state_t   : sequencer states (IDLE, RUN, FLUSH)
//   SA_DEFAULT_W : default operand/result width
//   sa_carry_in  : carry-in for bit 0 (subtract forces 1, add uses cin)
package serial_add_pkg;

  localparam int SA_DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } sa_state_t;

  // Subtract is A + ~B + 1, so the first carry-in is forced high.
  function automatic logic sa_carry_in(input logic sub, input logic cin);
    return sub | cin;
  endfunction

endpackage

// File: rtl/fulladder.sv
// Registered one-bit full adder cell (one-cycle latency, no reset).
// Ports: clk; a, b, cin in; sum, cout registered out.
module fulladder (
  input  logic clk,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum and carry are registered; the cell carries no reset on purpose.
  always_ff @(posedge clk) begin
    sum  <= a ^ b ^ cin;
    cout <= (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/serial_adder_top.sv
// Integration wrapper: sequencer plus the registered one-bit adder cell.
// Ports: clk, rst, start, sub, op_a[W], op_b[W], cin_in in;
//        busy, done, result[W], cout out.
module serial_adder_top
  import serial_add_pkg::*;
#(
  parameter int W = SA_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout
);

  logic fa_a_s;
  logic fa_b_s;
  logic fa_cin_s;
  logic fa_sum_s;
  logic fa_cout_s;

  serial_add_ctrl #(.W(W)) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sub     (sub),
    .op_a    (op_a),
    .op_b    (op_b),
    .cin_in  (cin_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .cout    (cout),
    .fa_a    (fa_a_s),
    .fa_b    (fa_b_s),
    .fa_cin  (fa_cin_s),
    .fa_sum  (fa_sum_s),
    .fa_cout (fa_cout_s)
  );

  fulladder u_fa (
    .clk  (clk),
    .a    (fa_a_s),
    .b    (fa_b_s),
    .cin  (fa_cin_s),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer driving a registered one-bit adder cell.
// Ports:
//   clk, rst (async, active high)
//   start, sub, op_a[W], op_b[W], cin_in : request and operands
//   busy, done, result[W], cout          : status and held result
//   fa_a, fa_b, fa_cin                   : drive to the adder cell
//   fa_sum, fa_cout                      : registered outputs of the cell
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int W = SA_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         fa_a,
  output logic         fa_b,
  output logic         fa_cin,
  input  logic         fa_sum,
  input  logic         fa_cout
);

  localparam int IW = $clog2(W) + 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);

  sa_state_t     state_r;
  sa_state_t     state_next_s;
  logic [W-1:0]  sa_r;
  logic [W-1:0]  sb_r;
  logic [W-1:0]  res_sr_r;
  logic [W-1:0]  result_r;
  logic [IW-1:0] idx_r;
  logic          sub_r;
  logic          cin_r;
  logic          cout_r;
  logic          done_r;
  logic          busy_s;
  logic          fa_a_s;
  logic          fa_b_s;
  logic          fa_cin_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (idx_r == IDX_LAST) begin
          state_next_s = FLUSH;
        end else begin
          state_next_s = RUN;
        end
      end
      FLUSH:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Cell drive and busy. Bit 0 takes the latched carry-in; later bits take the
  // cell's registered carry directly, so stale cell state is never consumed.
  always_comb begin
    busy_s   = 1'b0;
    fa_a_s   = 1'b0;
    fa_b_s   = 1'b0;
    fa_cin_s = 1'b0;
    case (state_r)
      RUN: begin
        busy_s = 1'b1;
        fa_a_s = sa_r[0];
        fa_b_s = sb_r[0];
        if (idx_r == {IW{1'b0}}) begin
          fa_cin_s = sa_carry_in(sub_r, cin_r);
        end else begin
          fa_cin_s = fa_cout;
        end
      end
      FLUSH:   busy_s = 1'b1;
      IDLE:    busy_s = 1'b0;
      default: busy_s = 1'b0;
    endcase
  end

  // Operand/result shift registers, bit index, held result and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_r     <= {W{1'b0}};
      sb_r     <= {W{1'b0}};
      res_sr_r <= {W{1'b0}};
      result_r <= {W{1'b0}};
      idx_r    <= {IW{1'b0}};
      sub_r    <= 1'b0;
      cin_r    <= 1'b0;
      cout_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            sa_r  <= op_a;
            sb_r  <= op_b ^ {W{sub}};
            sub_r <= sub;
            cin_r <= cin_in;
            idx_r <= {IW{1'b0}};
          end
        end
        RUN: begin
          sa_r  <= {1'b0, sa_r[W-1:1]};
          sb_r  <= {1'b0, sb_r[W-1:1]};
          idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
          // The cell returns bit idx-1 now; nothing valid is back yet at idx 0.
          if (idx_r != {IW{1'b0}}) begin
            res_sr_r <= {fa_sum, res_sr_r[W-1:1]};
          end
        end
        FLUSH: begin
          result_r <= {fa_sum, res_sr_r[W-1:1]};
          cout_r   <= fa_cout;
          done_r   <= 1'b1;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_s;
  assign done   = done_r;
  assign result = result_r;
  assign cout   = cout_r;
  assign fa_a   = fa_a_s;
  assign fa_b   = fa_b_s;
  assign fa_cin = fa_cin_s;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (W=8) paired with the adder cell,
// with the integration wrapper run in parallel on the same stimulus.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin_in;
  logic         busy, done, cout;
  logic [W-1:0] result;
  logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic         w_busy, w_done, w_cout;
  logic [W-1:0] w_result;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.W(W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .cin_in(cin_in), .busy(busy), .done(done), .result(result), .cout(cout),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout)
  );

  fulladder u_cell (
    .clk(clk), .a(fa_a), .b(fa_b), .cin(fa_cin), .sum(fa_sum), .cout(fa_cout)
  );

  serial_adder_top #(.W(W)) u_top (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .cin_in(cin_in), .busy(w_busy), .done(w_done), .result(w_result), .cout(w_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an accepted operation takes W+1 edges, then its
  // arithmetic result appears together with a one-cycle done.
  int           m_cnt;
  logic         m_done;
  logic [W-1:0] m_result;
  logic         m_cout;
  logic [W:0]   m_pend;
  logic [W-1:0] m_a, m_b;
  logic         m_c0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt    <= 0;
      m_done   <= 1'b0;
      m_result <= '0;
      m_cout   <= 1'b0;
      m_pend   <= '0;
      m_a      <= '0;
      m_b      <= '0;
      m_c0     <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt  <= m_cnt - 1;
      m_done <= (m_cnt == 1);
      if (m_cnt == 1) {m_cout, m_result} <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_a    <= op_a;
        m_b    <= sub ? ~op_b : op_b;
        m_c0   <= sub ? 1'b1 : cin_in;
        m_pend <= {1'b0, op_a} + {1'b0, (sub ? ~op_b : op_b)} + {{W{1'b0}}, (sub ? 1'b1 : cin_in)};
        m_cnt  <= W + 1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic compare();
    int k;
    int mask;
    logic ea, eb, ec;
    ea = 1'b0; eb = 1'b0; ec = 1'b0;
    if (m_cnt != 0) begin
      k = W + 1 - m_cnt;            // bit position being issued, W = flush
      if (k < W) begin
        mask = (1 << k) - 1;
        ea = m_a[k];
        eb = m_b[k];
        ec = ((((int'(m_a) & mask) + (int'(m_b) & mask) + int'(m_c0)) >> k) & 1) != 0;
      end
    end
    check("busy",     busy,     m_cnt != 0);
    check("done",     done,     m_done);
    check("result",   result,   m_result);
    check("cout",     cout,     m_cout);
    check("fa_a",     fa_a,     ea);
    check("fa_b",     fa_b,     eb);
    check("fa_cin",   fa_cin,   ec);
    check("w_busy",   w_busy,   m_cnt != 0);
    check("w_done",   w_done,   m_done);
    check("w_result", w_result, m_result);
    check("w_cout",   w_cout,   m_cout);
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
  endtask

  // One operation with hand-computed result, latency and busy length.
  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic ci,
                        input logic [W-1:0] exp_r, input logic exp_c);
    int n;
    int nb;
    op_a = a; op_b = b; sub = s; cin_in = ci; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    nb = busy ? 1 : 0;
    while (!done && n < 30) begin
      tick();
      n++;
      if (busy) nb++;
    end
    check({nm, "_latency"}, n, W + 1);
    check({nm, "_busy_cycles"}, nb, W + 1);
    check({nm, "_result"}, result, exp_r);
    check({nm, "_cout"}, cout, exp_c);
  endtask

  initial begin
    int n;
    int nd;
    rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0; cin_in = 1'b0;
    tick();
    tick();
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);

    // Release reset with start already high on the first edge.
    rst = 1'b0;
    run_op("t1_add", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
    run_op("t2_ripple", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1);
    run_op("t3_sub_a", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1);
    run_op("t3_sub_b", 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0);

    // start during RUN is dropped, not queued.
    op_a = 8'h12; op_b = 8'h34; sub = 1'b0; cin_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    op_a = 8'hFF; op_b = 8'hFF; cin_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (done) nd++;
    end
    check("t4_done_count", nd, 1);
    check("t4_result", result, 8'h46);
    check("t4_cout", cout, 1'b0);

    // Reset mid-operation: outputs clear at once and the operation vanishes.
    op_a = 8'hFF; op_b = 8'hFF; cin_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_result", result, 0);
    check("t5_rst_cout", cout, 0);
    check("t5_rst_fa", {fa_a, fa_b, fa_cin}, 0);
    tick();
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) nd++;
    end
    check("t5_no_done", nd, 0);
    run_op("t5_after", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);

    // start held high: the next accept lands on the done cycle, so done
    // pulses repeat every W+2 edges (W+1 busy cycles plus the done cycle).
    op_a = 8'h01; op_b = 8'h01; sub = 1'b0; cin_in = 1'b0; start = 1'b1;
    tick();
    op_a = 8'h02; op_b = 8'h03;
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    check("t6_first_result", result, 8'h02);
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    check("t6_done_period", n, W + 2);
    check("t6_second_result", result, 8'h05);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
